// File: rtl/alarm_ctrl.sv
// Alarm controller: BCD alarm-time setting, edge-triggered ring with auto-off, and snooze.
// state  | meaning
// IDLE   | armed and waiting for a rising match
// SET_H  | UP steps the alarm hour
// SET_M  | UP steps the alarm minute
// RING   | buzzer on, counting toward the auto-off
// SNOOZE | buzzer off, counting toward re-ring
module alarm_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE1S,
  input  logic [7:0] CUR_HOUR,
  input  logic [7:0] CUR_MIN,
  input  logic [7:0] CUR_SEC,
  input  logic       MODE,
  input  logic       UP,
  input  logic       SNZ,
  input  logic       STOP,
  input  logic       ALM_EN,
  output logic [7:0] ALM_HOUR,
  output logic [7:0] ALM_MIN,
  output logic [2:0] MD,
  output logic       BUZZ
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SET_H  = 3'd1,
    SET_M  = 3'd2,
    RING   = 3'd3,
    SNOOZE = 3'd4
  } state_t;

  state_t     state;
  logic [5:0] ring_cnt;
  logic [8:0] snz_cnt;
  logic       hit;
  logic       hit_d;

  function automatic logic [7:0] hour_inc(input logic [7:0] h);
    if (h == 8'h23)          hour_inc = 8'h00;
    else if (h[3:0] == 4'd9) hour_inc = {h[7:4] + 4'd1, 4'd0};
    else                     hour_inc = {h[7:4], h[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] min_inc(input logic [7:0] m);
    if (m == 8'h59)          min_inc = 8'h00;
    else if (m[3:0] == 4'd9) min_inc = {m[7:4] + 4'd1, 4'd0};
    else                     min_inc = {m[7:4], m[3:0] + 4'd1};
  endfunction

  assign hit  = ALM_EN && (CUR_HOUR == ALM_HOUR) && (CUR_MIN == ALM_MIN) && (CUR_SEC == 8'h00);
  assign MD   = state;
  assign BUZZ = (state == RING);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      ALM_HOUR <= 8'h07;
      ALM_MIN  <= 8'h00;
      ring_cnt <= '0;
      snz_cnt  <= '0;
      hit_d    <= 1'b0;
    end else begin
      // Only a rising match fires, so a held match after STOP cannot re-ring.
      hit_d <= hit;
      unique case (state)
        IDLE: begin
          if (MODE) begin
            state <= SET_H;
          end else if (hit && !hit_d) begin
            state    <= RING;
            ring_cnt <= '0;
          end
        end
        SET_H: begin
          if (MODE)    state    <= SET_M;
          else if (UP) ALM_HOUR <= hour_inc(ALM_HOUR);
        end
        SET_M: begin
          if (MODE)    state   <= IDLE;
          else if (UP) ALM_MIN <= min_inc(ALM_MIN);
        end
        RING: begin
          if (STOP || !ALM_EN) begin
            state <= IDLE;
          end else if (SNZ) begin
            state   <= SNOOZE;
            snz_cnt <= '0;
          end else if (CE1S) begin
            if (ring_cnt == 6'd59) state    <= IDLE;
            else                   ring_cnt <= ring_cnt + 6'd1;
          end
        end
        SNOOZE: begin
          if (STOP || !ALM_EN) begin
            state <= IDLE;
          end else if (CE1S) begin
            if (snz_cnt == 9'd299) begin
              state    <= RING;
              ring_cnt <= '0;
            end else begin
              snz_cnt <= snz_cnt + 9'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed vector table plus hand sequences for alarm_ctrl; expectations are hand-computed.
module tb_alarm_ctrl;

  logic       CLK = 1'b0;
  logic       RST, CE1S, MODE, UP, SNZ, STOP, ALM_EN;
  logic [7:0] CUR_HOUR, CUR_MIN, CUR_SEC;
  logic [7:0] ALM_HOUR, ALM_MIN;
  logic [2:0] MD;
  logic       BUZZ;

  int total = 0;
  int bad   = 0;

  alarm_ctrl dut (
    .CLK(CLK), .RST(RST), .CE1S(CE1S),
    .CUR_HOUR(CUR_HOUR), .CUR_MIN(CUR_MIN), .CUR_SEC(CUR_SEC),
    .MODE(MODE), .UP(UP), .SNZ(SNZ), .STOP(STOP), .ALM_EN(ALM_EN),
    .ALM_HOUR(ALM_HOUR), .ALM_MIN(ALM_MIN), .MD(MD), .BUZZ(BUZZ)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst, ce, mode, up, snz, stop, en;
    logic [7:0] h, m, s;
    logic [2:0] md;
    logic       buzz;
    logic [7:0] ah, am;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, ce, mode, up, snz, stop, en,
                     input logic [7:0] h, m, s,
                     input logic [2:0] md, input logic buzz,
                     input logic [7:0] ah, am);
    vec_t v;
    v.rst = rst; v.ce = ce; v.mode = mode; v.up = up; v.snz = snz; v.stop = stop; v.en = en;
    v.h = h; v.m = m; v.s = s; v.md = md; v.buzz = buzz; v.ah = ah; v.am = am;
    vecs.push_back(v);
  endtask

  // Drive inputs, take one rising edge, sample 1 time unit after it, release pulses.
  task automatic step(input logic rst, ce, mode, up, snz, stop, en,
                      input logic [7:0] h, m, s);
    RST = rst; CE1S = ce; MODE = mode; UP = up; SNZ = snz; STOP = stop; ALM_EN = en;
    CUR_HOUR = h; CUR_MIN = m; CUR_SEC = s;
    @(posedge CLK);
    #1;
    RST = 1'b0; CE1S = 1'b0; MODE = 1'b0; UP = 1'b0; SNZ = 1'b0; STOP = 1'b0;
  endtask

  task automatic check(input string name, input logic [2:0] md, input logic buzz,
                       input logic [7:0] ah, input logic [7:0] am);
    total++;
    if (MD !== md || BUZZ !== buzz || ALM_HOUR !== ah || ALM_MIN !== am) begin
      bad++;
      $display("FAIL %s: got md=%0d buzz=%b alm=%h:%h, want md=%0d buzz=%b alm=%h:%h",
               name, MD, BUZZ, ALM_HOUR, ALM_MIN, md, buzz, ah, am);
    end
  endtask

  initial begin
    RST = 1'b1; CE1S = 0; MODE = 0; UP = 0; SNZ = 0; STOP = 0; ALM_EN = 1;
    CUR_HOUR = 8'h12; CUR_MIN = 8'h34; CUR_SEC = 8'h56;

    //   rst ce md up sz st en  hour   min    sec    md   bz  ah     am
    add(1, 0, 0, 0, 0, 0, 1, 8'h12, 8'h34, 8'h56, 3'd0, 0, 8'h07, 8'h00);
    add(0, 0, 0, 0, 1, 0, 1, 8'h12, 8'h34, 8'h56, 3'd0, 0, 8'h07, 8'h00);
    add(0, 0, 1, 0, 0, 0, 1, 8'h12, 8'h34, 8'h56, 3'd1, 0, 8'h07, 8'h00);
    add(0, 0, 0, 1, 0, 0, 1, 8'h12, 8'h34, 8'h56, 3'd1, 0, 8'h08, 8'h00);
    add(0, 0, 0, 1, 0, 0, 1, 8'h12, 8'h34, 8'h56, 3'd1, 0, 8'h09, 8'h00);
    add(0, 0, 0, 1, 0, 0, 1, 8'h12, 8'h34, 8'h56, 3'd1, 0, 8'h10, 8'h00);
    add(0, 0, 1, 0, 0, 0, 1, 8'h12, 8'h34, 8'h56, 3'd2, 0, 8'h10, 8'h00);
    add(0, 0, 0, 1, 0, 0, 1, 8'h12, 8'h34, 8'h56, 3'd2, 0, 8'h10, 8'h01);
    add(0, 0, 1, 1, 0, 0, 1, 8'h12, 8'h34, 8'h56, 3'd0, 0, 8'h10, 8'h01);
    add(0, 0, 1, 0, 0, 0, 1, 8'h12, 8'h34, 8'h56, 3'd1, 0, 8'h10, 8'h01);
    add(0, 0, 1, 1, 0, 0, 1, 8'h12, 8'h34, 8'h56, 3'd2, 0, 8'h10, 8'h01);
    add(0, 0, 1, 0, 0, 0, 1, 8'h12, 8'h34, 8'h56, 3'd0, 0, 8'h10, 8'h01);
    add(1, 0, 0, 0, 0, 0, 1, 8'h12, 8'h34, 8'h56, 3'd0, 0, 8'h07, 8'h00);
    add(0, 0, 0, 0, 0, 0, 1, 8'h06, 8'h59, 8'h59, 3'd0, 0, 8'h07, 8'h00);
    add(0, 0, 0, 0, 0, 0, 1, 8'h07, 8'h00, 8'h00, 3'd3, 1, 8'h07, 8'h00);
    add(0, 0, 1, 0, 0, 0, 1, 8'h07, 8'h00, 8'h00, 3'd3, 1, 8'h07, 8'h00);
    add(0, 0, 0, 1, 0, 0, 1, 8'h07, 8'h00, 8'h00, 3'd3, 1, 8'h07, 8'h00);
    add(0, 0, 0, 0, 0, 1, 1, 8'h07, 8'h00, 8'h00, 3'd0, 0, 8'h07, 8'h00);
    add(0, 0, 0, 0, 0, 0, 1, 8'h07, 8'h00, 8'h00, 3'd0, 0, 8'h07, 8'h00);
    add(0, 0, 0, 0, 0, 0, 1, 8'h07, 8'h00, 8'h01, 3'd0, 0, 8'h07, 8'h00);
    add(0, 0, 0, 0, 0, 0, 1, 8'h07, 8'h00, 8'h00, 3'd3, 1, 8'h07, 8'h00);
    add(0, 0, 0, 0, 1, 1, 1, 8'h07, 8'h00, 8'h00, 3'd0, 0, 8'h07, 8'h00);
    add(0, 0, 0, 0, 0, 0, 0, 8'h07, 8'h00, 8'h01, 3'd0, 0, 8'h07, 8'h00);
    add(0, 0, 0, 0, 0, 0, 0, 8'h07, 8'h00, 8'h00, 3'd0, 0, 8'h07, 8'h00);
    add(0, 0, 0, 0, 0, 0, 1, 8'h07, 8'h00, 8'h00, 3'd3, 1, 8'h07, 8'h00);
    add(0, 0, 0, 0, 0, 0, 0, 8'h07, 8'h00, 8'h00, 3'd0, 0, 8'h07, 8'h00);
    add(0, 0, 0, 0, 0, 0, 1, 8'h07, 8'h00, 8'h01, 3'd0, 0, 8'h07, 8'h00);
    add(0, 0, 1, 0, 0, 0, 1, 8'h07, 8'h00, 8'h00, 3'd1, 0, 8'h07, 8'h00);
    add(0, 0, 1, 0, 0, 0, 1, 8'h07, 8'h00, 8'h00, 3'd2, 0, 8'h07, 8'h00);
    add(0, 0, 1, 0, 0, 0, 1, 8'h07, 8'h00, 8'h00, 3'd0, 0, 8'h07, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].ce, vecs[i].mode, vecs[i].up, vecs[i].snz, vecs[i].stop,
           vecs[i].en, vecs[i].h, vecs[i].m, vecs[i].s);
      check($sformatf("vec%0d", i), vecs[i].md, vecs[i].buzz, vecs[i].ah, vecs[i].am);
    end

    // Auto-off: the 60th CE1S in RING returns to IDLE.
    step(1, 0, 0, 0, 0, 0, 1, 8'h06, 8'h59, 8'h59);
    step(0, 0, 0, 0, 0, 0, 1, 8'h07, 8'h00, 8'h00);
    check("autooff_enter", 3'd3, 1, 8'h07, 8'h00);
    for (int i = 0; i < 59; i++) step(0, 1, 0, 0, 0, 0, 1, 8'h07, 8'h00, 8'h00);
    check("autooff_59", 3'd3, 1, 8'h07, 8'h00);
    step(0, 1, 0, 0, 0, 0, 1, 8'h07, 8'h00, 8'h00);
    check("autooff_60", 3'd0, 0, 8'h07, 8'h00);

    // Snooze: 300 CE1S pulses bring the ring back, STOP ends it.
    step(0, 0, 0, 0, 0, 0, 1, 8'h07, 8'h00, 8'h01);
    step(0, 0, 0, 0, 0, 0, 1, 8'h07, 8'h00, 8'h00);
    step(0, 0, 0, 0, 1, 0, 1, 8'h07, 8'h00, 8'h00);
    check("snz_enter", 3'd4, 0, 8'h07, 8'h00);
    for (int i = 0; i < 299; i++) step(0, 1, 0, 0, 0, 0, 1, 8'h07, 8'h00, 8'h00);
    check("snz_299", 3'd4, 0, 8'h07, 8'h00);
    step(0, 1, 0, 0, 0, 0, 1, 8'h07, 8'h00, 8'h00);
    check("snz_300", 3'd3, 1, 8'h07, 8'h00);
    step(0, 1, 0, 0, 0, 0, 1, 8'h07, 8'h00, 8'h00);
    check("ring_cnt_cleared", 3'd3, 1, 8'h07, 8'h00);
    step(0, 0, 0, 0, 0, 1, 1, 8'h07, 8'h00, 8'h00);
    check("snz_stop", 3'd0, 0, 8'h07, 8'h00);

    // Reset in the middle of SNOOZE.
    step(0, 0, 0, 0, 0, 0, 1, 8'h07, 8'h00, 8'h01);
    step(0, 0, 0, 0, 0, 0, 1, 8'h07, 8'h00, 8'h00);
    step(0, 0, 0, 0, 1, 0, 1, 8'h07, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, 1, 8'h07, 8'h00, 8'h00);
    check("snz_mid", 3'd4, 0, 8'h07, 8'h00);
    step(1, 1, 1, 1, 1, 1, 1, 8'h07, 8'h00, 8'h00);
    check("rst_mid_snz", 3'd0, 0, 8'h07, 8'h00);

    // Setting wrap: hour 07 +17 -> 00, minute 00 +61 -> 01.
    step(0, 0, 1, 0, 0, 0, 1, 8'h12, 8'h34, 8'h56);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 0, 0, 1, 8'h12, 8'h34, 8'h56);
    check("hour_23", 3'd1, 0, 8'h23, 8'h00);
    step(0, 0, 0, 1, 0, 0, 1, 8'h12, 8'h34, 8'h56);
    check("hour_wrap", 3'd1, 0, 8'h00, 8'h00);
    step(0, 0, 1, 0, 0, 0, 1, 8'h12, 8'h34, 8'h56);
    for (int i = 0; i < 59; i++) step(0, 0, 0, 1, 0, 0, 1, 8'h12, 8'h34, 8'h56);
    check("min_59", 3'd2, 0, 8'h00, 8'h59);
    step(0, 0, 0, 1, 0, 0, 1, 8'h12, 8'h34, 8'h56);
    check("min_wrap", 3'd2, 0, 8'h00, 8'h00);
    step(0, 0, 0, 1, 0, 0, 1, 8'h12, 8'h34, 8'h56);
    step(0, 0, 1, 0, 0, 0, 1, 8'h12, 8'h34, 8'h56);
    check("set_done", 3'd0, 0, 8'h00, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port CE1S  input  1  one-CLK-wide pulse once per second.
REQ-004 SHALL have ports CUR_HOUR, CUR_MIN, CUR_SEC  input  8 each  current time, packed BCD {tens, ones}.
REQ-005 SHALL have port MODE  input  1  one-cycle button pulse; advances the setting sequence.
REQ-006 SHALL have port UP  input  1  one-cycle button pulse; increments the selected alarm field.
REQ-007 SHALL have port SNZ  input  1  one-cycle button pulse; snooze request.
REQ-008 SHALL have port STOP  input  1  one-cycle button pulse; silences the alarm.
REQ-009 SHALL have port ALM_EN  input  1  level; alarm armed when 1.
REQ-010 SHALL have ports ALM_HOUR, ALM_MIN  output  8 each  stored alarm time, packed BCD.
REQ-011 SHALL have port MD  output  3  current state code.
REQ-012 SHALL have port BUZZ  output  1  buzzer drive.

Function
REQ-013 SHALL implement states IDLE=3'd0, SET_H=3'd1, SET_M=3'd2, RING=3'd3, SNOOZE=3'd4; MD = state register.
REQ-014 SHALL compute hit = ALM_EN & (CUR_HOUR==ALM_HOUR) & (CUR_MIN==ALM_MIN) & (CUR_SEC==8'h00), register it as hit_d every cycle, in every state.
REQ-015 IDLE: MODE -> SET_H; else hit & ~hit_d -> RING; otherwise stay; MODE has priority over hit.
REQ-016 SET_H: UP increments ALM_HOUR in BCD 00..23, 23 wraps to 00, ones 9 carries into tens; MODE -> SET_M.
REQ-017 SET_M: UP increments ALM_MIN in BCD 00..59, 59 wraps to 00; MODE -> IDLE.
REQ-018 In SET_H/SET_M, MODE and UP in the same cycle: transition taken, no increment.
REQ-019 Alarm SHALL NOT trigger in SET_H or SET_M.
REQ-020 RING entry SHALL clear ring counter (6-bit, 0..59); each CE1S in RING increments it.
REQ-021 RING exits, priority high to low: STOP -> IDLE; ALM_EN=0 -> IDLE; SNZ -> SNOOZE; CE1S with ring counter==59 -> IDLE (auto-off after 60 CE1S pulses).
REQ-022 SNOOZE entry SHALL clear snooze counter (9-bit, 0..299); each CE1S increments it.
REQ-023 SNOOZE exits, priority high to low: STOP -> IDLE; ALM_EN=0 -> IDLE; CE1S with snooze counter==299 -> RING (ring counter cleared).
REQ-024 MODE and UP SHALL be ignored in RING and SNOOZE; SNZ ignored outside RING.
REQ-025 BUZZ SHALL be 1 exactly when state==RING, decoded from the state register; first BUZZ cycle is the cycle after the triggering edge.
REQ-026 After STOP while hit remains 1, no re-trigger; next trigger requires hit to fall and rise again.
REQ-027 Alarm time changes SHALL take effect on the cycle after the UP pulse.

Reset
REQ-028 On RST=1 at a CLK edge: state=IDLE, ALM_HOUR=8'h07, ALM_MIN=8'h00, ring and snooze counters=0, hit_d=0, BUZZ=0, MD=3'd0.
REQ-029 RST SHALL override all other inputs, including mid-RING and mid-SNOOZE.

Verification
REQ-030 Reset: pulse RST -> ALM_HOUR=07, ALM_MIN=00, MD=0, BUZZ=0.
REQ-031 Set wrap: MODE, 17 UP pulses (07->00), MODE, 61 UP pulses, MODE -> ALM_HOUR=00, ALM_MIN=01, MD back to 0.
REQ-032 Trigger/auto-off: alarm 07:00, ALM_EN=1, drive time 06:59:59 -> 07:00:00 -> BUZZ=1 next cycle; 60 CE1S -> BUZZ=0, MD=0.
REQ-033 Snooze: in RING pulse SNZ -> MD=4, BUZZ=0; 300 CE1S -> MD=3, BUZZ=1; STOP -> MD=0.
REQ-034 No re-fire: STOP during 07:00:00 with time held -> stays IDLE; time to 07:00:01 and back to 07:00:00 -> RING again.
REQ-035 Disable/priority: ALM_EN=0 at match -> no RING; in RING with STOP and SNZ same cycle -> IDLE; RST mid-SNOOZE -> MD=0.
